regfile_wr_arb: RTL and testbench
=================================

Name: regfile_wr_arb

Overview:
- Shares the register file's single write port between the pipeline writeback stage and a long-latency unit (divider/multi-cycle load).
- The pipeline has priority. Long-unit results are queued in a small FIFO and drained into idle write slots.
- Guarantees progress for queued results with a starvation counter that requests a one-cycle pipeline stall.
- Exports pending-write hits so decode can hold dependent reads. Sits between MEM/WB, the long-latency unit and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, long-unit result queue entries (>=1)
- STARVE_MAX, 4, consecutive lost cycles before a forced drain (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- wb_we  in  1  pipeline writeback enable (no backpressure)
- wb_waddr  in  ADDR_W  pipeline write address
- wb_wdata  in  DATA_W  pipeline write data
- lu_valid  in  1  long unit presents a result
- lu_ready  out  1  queue can accept a result
- lu_waddr  in  ADDR_W  long-unit write address
- lu_wdata  in  DATA_W  long-unit write data
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- stall_req  out  1  registered; pipeline must hold its WB stage this cycle
- raddr1  in  ADDR_W  decode read address 1
- raddr2  in  ADDR_W  decode read address 2
- pend_hit1  out  1  a valid queued entry targets raddr1
- pend_hit2  out  1  a valid queued entry targets raddr2
- q_count  out  log2(FIFO_DEPTH)+1  number of valid queued entries

Behaviour:
- Reset (async, rst=1):
  - Queue emptied, starvation counter=0, stall_req=0.
  - While rst=1, lu_ready, rf_we, pend_hit1/2 and q_count are all forced to 0.
  - Reset mid-drain discards all queued entries.
- Enqueue:
  - lu_ready = !full, computed from the queue state at cycle start.
  - A dequeue in the same cycle does not free a slot for that cycle.
  - A handshake (lu_valid & lu_ready) with lu_waddr==0 completes but is dropped, not queued.
  - An entry enqueued in cycle N is eligible for write no earlier than N+1.
- Grant, priority per cycle, combinational to rf_*:
  1. stall_req=1: grant the queue head if one is valid; wb_* is ignored because the pipeline re-presents it next cycle.
  2. wb_we=1 and wb_waddr!=0: grant WB.
  3. Queue non-empty: grant and dequeue the head.
  4. Otherwise rf_we=0.
- wb_we with wb_waddr==0 never asserts rf_we and leaves the slot free for the queue.
- rf_waddr/rf_wdata are 0 when rf_we=0.
- WAW kill: when WB is granted, every valid queued entry whose address equals wb_waddr is invalidated in the same clock edge. The stale long-unit result must never overwrite the newer one.
  - Invalidated entries are compacted out, so the queue stays FIFO-ordered.
  - q_count drops accordingly.
- Starvation:
  - The counter increments on each cycle where the queue is non-empty and WB is granted.
  - It clears on any dequeue or when the queue becomes empty.
  - When the increment would reach STARVE_MAX, stall_req is set for the next cycle and the counter clears.
  - stall_req lasts exactly one cycle.
  - If the queue emptied via a kill, the stall cycle grants nothing.
- pend_hit1/2 are combinational compares of raddr against valid entries; address 0 never hits.
- q_count is updated at clock edges to reflect enqueue, dequeue and kill effects.

Test Plan:
- Reset release, idle inputs -> lu_ready=1, rf_we=0, q_count=0, stall_req=0.
- LU result (r5, 0xDEADBEEF) with wb_we=0 -> q_count=1 next cycle; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF the cycle after; queue empty following that.
- Two LU results, then continuous WB writes to r1 -> after 4 cycles stall_req=1 for one cycle; r-head written in that cycle; the held WB write then goes through; second entry is treated the same way later.
- Queue holds r7 while WB writes r7=0x1 -> entry killed; q_count decrements; r7 is never written with the LU value; pend_hit for raddr1=7 drops to 0.
- Fill the queue (2 entries) -> lu_ready=0; lu_valid held is not accepted until the cycle after a dequeue. An LU result to r0 completes its handshake with q_count unchanged.
- Assert rst with 2 entries queued and stall_req pending -> all outputs 0 immediately (asynchronously); after release q_count=0 and no stale writes occur.

Source files
------------

// File: rtl/regfile_wr_arb.sv
// Shares the register-file write port between WB (priority) and a queued long-unit result stream.
// Grant is combinational. The long unit sees lu_ready=!full. A registered stall_req forces a drain after STARVE_MAX lost cycles.
module regfile_wr_arb #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_we,
  input  logic [ADDR_W-1:0]             wb_waddr,
  input  logic [DATA_W-1:0]             wb_wdata,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [ADDR_W-1:0]             lu_waddr,
  input  logic [DATA_W-1:0]             lu_wdata,
  output logic                          rf_we,
  output logic [ADDR_W-1:0]             rf_waddr,
  output logic [DATA_W-1:0]             rf_wdata,
  output logic                          stall_req,
  input  logic [ADDR_W-1:0]             raddr1,
  input  logic [ADDR_W-1:0]             raddr2,
  output logic                          pend_hit1,
  output logic                          pend_hit2,
  output logic [$clog2(FIFO_DEPTH):0]   q_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  // Queue is kept compacted: valid entries occupy slots 0..n-1, head at slot 0.
  logic [FIFO_DEPTH-1:0] r_q_vld;
  logic [ADDR_W-1:0]     r_q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]     r_q_data [FIFO_DEPTH];
  logic [SW-1:0]         r_starve;
  logic                  r_stall;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_wb_ok;
  logic                  w_enq;
  logic                  w_grant_q;
  logic                  w_grant_wb;
  logic [FIFO_DEPTH-1:0] w_keep;
  logic [FIFO_DEPTH-1:0] w_n_vld;
  logic [ADDR_W-1:0]     w_n_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]     w_n_data [FIFO_DEPTH];
  int                    w_kcnt;
  logic [CW-1:0]         w_cnt;
  logic [SW-1:0]         w_n_starve;
  logic                  w_n_stall;

  assign w_empty = !r_q_vld[0];
  assign w_full  = r_q_vld[FIFO_DEPTH-1];
  assign w_wb_ok = wb_we && (wb_waddr != '0);
  assign w_enq   = lu_valid && !w_full && (lu_waddr != '0);

  always_comb begin
    w_grant_q  = 1'b0;
    w_grant_wb = 1'b0;
    if (r_stall) begin
      w_grant_q = !w_empty;
    end else if (w_wb_ok) begin
      w_grant_wb = 1'b1;
    end else begin
      w_grant_q = !w_empty;
    end
  end

  assign rf_we = !rst && (w_grant_q || w_grant_wb);

  always_comb begin
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst && w_grant_wb) begin
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (!rst && w_grant_q) begin
      rf_waddr = r_q_addr[0];
      rf_wdata = r_q_data[0];
    end
  end

  // Drop the dequeued head and any entry made stale by the WB write, compact, then append.
  always_comb begin
    w_keep  = '0;
    w_n_vld = '0;
    w_kcnt  = 0;
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      w_n_addr[j] = '0;
      w_n_data[j] = '0;
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_keep[i] = r_q_vld[i]
                  && !(w_grant_q && (i == 0))
                  && !(w_grant_wb && (r_q_addr[i] == wb_waddr));
      if (w_keep[i]) begin
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          if (j == w_kcnt) begin
            w_n_vld[j]  = 1'b1;
            w_n_addr[j] = r_q_addr[i];
            w_n_data[j] = r_q_data[i];
          end
        end
        w_kcnt = w_kcnt + 1;
      end
    end
    if (w_enq) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (j == w_kcnt) begin
          w_n_vld[j]  = 1'b1;
          w_n_addr[j] = lu_waddr;
          w_n_data[j] = lu_wdata;
        end
      end
    end
  end

  always_comb begin
    w_n_stall  = 1'b0;
    w_n_starve = r_starve;
    if (w_grant_q) begin
      w_n_starve = '0;
    end else if (!w_empty && w_grant_wb) begin
      if (int'(r_starve) + 1 >= STARVE_MAX) begin
        w_n_stall  = 1'b1;
        w_n_starve = '0;
      end else begin
        w_n_starve = r_starve + 1'b1;
      end
    end
    if (!w_n_vld[0]) begin
      w_n_starve = '0;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_cnt = w_cnt + CW'(r_q_vld[i]);
    end
  end

  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_q_vld[i] && (r_q_addr[i] == raddr1) && (raddr1 != '0)) pend_hit1 = 1'b1;
      if (r_q_vld[i] && (r_q_addr[i] == raddr2) && (raddr2 != '0)) pend_hit2 = 1'b1;
    end
    if (rst) begin
      pend_hit1 = 1'b0;
      pend_hit2 = 1'b0;
    end
  end

  assign lu_ready  = !rst && !w_full;
  assign q_count   = rst ? '0 : w_cnt;
  assign stall_req = r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_vld  <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_addr[i] <= '0;
        r_q_data[i] <= '0;
      end
    end else begin
      r_q_vld  <= w_n_vld;
      r_starve <= w_n_starve;
      r_stall  <= w_n_stall;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_q_addr[i] <= w_n_addr[i];
        r_q_data[i] <= w_n_data[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb: drain, starvation stall, WAW kill, full queue, r0 drop, async reset.
module tb_regfile_wr_arb;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic [1:0]  q_count;

  int n_vec  = 0;
  int n_miss = 0;

  regfile_wr_arb dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req),
    .raddr1(raddr1), .raddr2(raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    check({tag, ".rf_we"}, rf_we, we);
    check({tag, ".rf_waddr"}, rf_waddr, a);
    check({tag, ".rf_wdata"}, rf_wdata, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    wb_we    = we;
    wb_waddr = wa;
    wb_wdata = wd;
    lu_valid = lv;
    lu_waddr = la;
    lu_wdata = ld;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    raddr1 = '0;
    raddr2 = '0;
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h55;
    lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
    #3;
    check("rst.lu_ready", lu_ready, 1'b0);
    check("rst.rf_we", rf_we, 1'b0);
    check("rst.q_count", q_count, 2'd0);
    check("rst.stall", stall_req, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check("idle.lu_ready", lu_ready, 1'b1);
    chk_rf("idle", 0, 0, 0);
    check("idle.q_count", q_count, 2'd0);
    check("idle.stall", stall_req, 1'b0);

    // Single long-unit result drains on the next idle slot.
    tick(); drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    check("lu1.lu_ready", lu_ready, 1'b1);
    chk_rf("lu1.c0", 0, 0, 0);
    tick(); raddr1 = 5'd5; drive(0, 0, 0, 0, 0, 0);
    check("lu1.q_count", q_count, 2'd1);
    check("lu1.pend1", pend_hit1, 1'b1);
    chk_rf("lu1.c1", 1, 5'd5, 32'hDEADBEEF);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("lu1.q_empty", q_count, 2'd0);
    check("lu1.pend1_clr", pend_hit1, 1'b0);
    chk_rf("lu1.c2", 0, 0, 0);
    raddr1 = '0;

    // Starvation: two queued entries under continuous WB to r1.
    tick(); drive(1, 5'd1, 32'h1001, 1, 5'd3, 32'h33);
    chk_rf("stv.c0", 1, 5'd1, 32'h1001);
    tick(); drive(1, 5'd1, 32'h1001, 1, 5'd4, 32'h44);
    check("stv.c1.q", q_count, 2'd1);
    tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("stv.c2.q", q_count, 2'd2);
    check("stv.c2.lu_ready", lu_ready, 1'b0);
    for (int c = 3; c < 5; c++) begin
      tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
      check("stv.pre_stall1", stall_req, 1'b0);
    end
    tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("stv.c5.stall", stall_req, 1'b1);
    chk_rf("stv.c5", 1, 5'd3, 32'h33);
    tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("stv.c6.stall", stall_req, 1'b0);
    check("stv.c6.q", q_count, 2'd1);
    chk_rf("stv.c6", 1, 5'd1, 32'h1001);
    for (int c = 7; c < 10; c++) begin
      tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
      check("stv.pre_stall2", stall_req, 1'b0);
    end
    tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("stv.c10.stall", stall_req, 1'b1);
    chk_rf("stv.c10", 1, 5'd4, 32'h44);
    tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("stv.c11.stall", stall_req, 1'b0);
    check("stv.c11.q", q_count, 2'd0);
    chk_rf("stv.c11", 1, 5'd1, 32'h1001);

    // WAW kill: WB to r7 invalidates the queued r7 result.
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd7, 32'hAAAA7777);
    tick(); raddr1 = 5'd7; raddr2 = 5'd7; drive(1, 5'd7, 32'h1, 0, 0, 0);
    check("kill.pend1", pend_hit1, 1'b1);
    check("kill.pend2", pend_hit2, 1'b1);
    check("kill.q1", q_count, 2'd1);
    chk_rf("kill.wb", 1, 5'd7, 32'h1);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("kill.q0", q_count, 2'd0);
    check("kill.pend1_clr", pend_hit1, 1'b0);
    check("kill.pend2_clr", pend_hit2, 1'b0);
    chk_rf("kill.after", 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("kill.after2.rf_we", rf_we, 1'b0);

    // Killing the head compacts the queue; the younger entry becomes head.
    tick(); raddr1 = '0; raddr2 = '0; drive(1, 5'd2, 32'h22, 1, 5'd8, 32'h88);
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd9, 32'h99);
    check("cmp.q1", q_count, 2'd1);
    tick(); drive(1, 5'd8, 32'h8, 0, 0, 0);
    check("cmp.q2", q_count, 2'd2);
    chk_rf("cmp.wb8", 1, 5'd8, 32'h8);
    tick(); raddr1 = 5'd9; raddr2 = 5'd8; drive(0, 0, 0, 0, 0, 0);
    check("cmp.q_after_kill", q_count, 2'd1);
    check("cmp.pend9", pend_hit1, 1'b1);
    check("cmp.pend8", pend_hit2, 1'b0);
    chk_rf("cmp.drain9", 1, 5'd9, 32'h99);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("cmp.q0", q_count, 2'd0);
    raddr1 = '0; raddr2 = '0;

    // Full queue backpressure, then r0 handshake and wb to r0.
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd10, 32'hA0);
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd11, 32'hB0);
    check("full.f1.ready", lu_ready, 1'b1);
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd12, 32'hC0);
    check("full.f2.ready", lu_ready, 1'b0);
    check("full.f2.q", q_count, 2'd2);
    tick(); drive(0, 0, 0, 1, 5'd12, 32'hC0);
    check("full.f3.ready", lu_ready, 1'b0);
    chk_rf("full.f3", 1, 5'd10, 32'hA0);
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd12, 32'hC0);
    check("full.f4.ready", lu_ready, 1'b1);
    check("full.f4.q", q_count, 2'd1);
    chk_rf("full.f4", 1, 5'd2, 32'h22);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("full.f5.q", q_count, 2'd2);
    chk_rf("full.f5", 1, 5'd11, 32'hB0);
    tick(); drive(1, 5'd0, 32'h123, 1, 5'd0, 32'hFF);
    check("r0.ready", lu_ready, 1'b1);
    check("r0.q", q_count, 2'd1);
    chk_rf("r0.f6", 1, 5'd12, 32'hC0);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("r0.q_after", q_count, 2'd0);
    chk_rf("r0.f7", 0, 0, 0);

    // Stall after a kill emptied the queue grants nothing.
    tick(); drive(1, 5'd2, 32'h22, 1, 5'd15, 32'hF0);
    for (int c = 1; c < 4; c++) begin
      tick(); drive(1, 5'd2, 32'h22, 0, 0, 0);
    end
    tick(); drive(1, 5'd15, 32'h5, 0, 0, 0);
    chk_rf("kst.kill", 1, 5'd15, 32'h5);
    tick(); drive(1, 5'd2, 32'h22, 0, 0, 0);
    check("kst.stall", stall_req, 1'b1);
    check("kst.q", q_count, 2'd0);
    chk_rf("kst.empty_stall", 0, 0, 0);
    tick(); drive(1, 5'd2, 32'h22, 0, 0, 0);
    check("kst.stall_clr", stall_req, 1'b0);
    chk_rf("kst.wb", 1, 5'd2, 32'h22);

    // Async reset with two entries queued and a stall pending.
    tick(); drive(1, 5'd1, 32'h1001, 1, 5'd13, 32'hD0);
    tick(); drive(1, 5'd1, 32'h1001, 1, 5'd14, 32'hE0);
    for (int c = 2; c < 5; c++) begin
      tick(); drive(1, 5'd1, 32'h1001, 0, 0, 0);
    end
    tick(); raddr1 = 5'd13; drive(1, 5'd1, 32'h1001, 0, 0, 0);
    check("ar.stall", stall_req, 1'b1);
    check("ar.q", q_count, 2'd2);
    check("ar.pend1", pend_hit1, 1'b1);
    chk_rf("ar.drain", 1, 5'd13, 32'hD0);
    rst = 1'b1;
    #1;
    check("ar.async.stall", stall_req, 1'b0);
    check("ar.async.q", q_count, 2'd0);
    check("ar.async.ready", lu_ready, 1'b0);
    check("ar.async.pend1", pend_hit1, 1'b0);
    chk_rf("ar.async", 0, 0, 0);
    tick(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    check("ar.rel.q", q_count, 2'd0);
    check("ar.rel.ready", lu_ready, 1'b1);
    check("ar.rel.pend1", pend_hit1, 1'b0);
    check("ar.rel.stall", stall_req, 1'b0);
    chk_rf("ar.rel", 0, 0, 0);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("ar.rel2.rf_we", rf_we, 1'b0);
    check("ar.rel2.stall", stall_req, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
